uart_tx_fifo_engine: RTL

Parametrised next-generation UART transmitter with a built-in transmit FIFO.
- Data length is selectable from 5 to 8 bits.
- Parity can be none, even or odd.
- Frames use 1 or 2 stop bits.
- Baud rate is selected from a table derived from the clock frequency.
- Sits between the CPU/bus write path and the serial TX pin. The host can queue up to DEPTH words without waiting per character.

---
 rtl/uart_pkg.sv | 48 ++++
 rtl/uart_tx_fifo_engine_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo_engine.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine.
//   - state_e    : transmitter FSM states
//   - LEN_*      : encoding of the 2-bit data-length selector
//   - baud_rate  : baud-rate table, indices 12..15 clamp to the fastest rate
//   - baud_div   : clocks per bit for a given clock frequency and index
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam int unsigned NUM_RATES = 12;

  function automatic int unsigned baud_rate(input logic [3:0] idx);
    case (idx)
      4'd0:    return 300;
      4'd1:    return 1200;
      4'd2:    return 2400;
      4'd3:    return 4800;
      4'd4:    return 9600;
      4'd5:    return 19200;
      4'd6:    return 38400;
      4'd7:    return 57600;
      4'd8:    return 115200;
      4'd9:    return 230400;
      4'd10:   return 460800;
      default: return 921600;
    endcase
  endfunction

  // Truncating divide; a clock slower than the baud rate still gets one clock per bit.
  function automatic logic [31:0] baud_div(input int unsigned clk_hz, input logic [3:0] idx);
    int unsigned d;
    d = clk_hz / baud_rate(idx);
    if (d == 0) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_engine_fifo.sv
// uart_sync_fifo: DEPTH x 8 synchronous FIFO with first-word-fall-through read.
//   clk_i, rst_i      : clock, synchronous active-high reset (flushes contents)
//   push_i, wdata_i   : write strobe and data (ignored while full)
//   pop_i, rdata_o    : read strobe (ignored while empty), head word
//   full_o, empty_o   : occupancy flags
//   count_o           : number of stored words
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [7:0]    wdata_i,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_engine.sv
// UART transmitter with a transmit FIFO in front of it.
//   clk, rst         : clock, synchronous active-high reset (aborts frame, flushes FIFO)
//   load, data_in    : host write strobe and character
//   len, p_en, ohel, two_stop, baud : frame configuration, sampled at frame start
//   txrdy            : FIFO can accept a word
//   tx               : registered serial output, idles high
//   busy             : frame on the line
//   empty, count     : FIFO status
//   ovf              : sticky, a load arrived while the FIFO was full
module uart_tx_fifo_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int          DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [7:0]               data_in,
  input  logic [1:0]               len,
  input  logic                     p_en,
  input  logic                     ohel,
  input  logic                     two_stop,
  input  logic [3:0]               baud,
  output logic                     txrdy,
  output logic                     tx,
  output logic                     busy,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata;
  logic        push;
  logic        pop;
  logic        start_frame;
  logic        bit_end;
  logic        last_data;
  logic [31:0] div_tab [16];

  state_e      state_q, state_d;
  logic [31:0] baud_cnt_q, baud_cnt_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [1:0]  len_q, len_d;
  logic        p_en_q, p_en_d;
  logic        ohel_q, ohel_d;
  logic        two_stop_q, two_stop_d;
  logic        tx_q, tx_d;
  logic        busy_q;
  logic        ovf_q;

  // Divisors are constants of CLK_HZ; the runtime selection is a plain mux.
  for (genvar g = 0; g < 16; g++) begin : g_div
    assign div_tab[g] = baud_div(CLK_HZ, 4'(g));
  end

  assign push  = load & ~fifo_full;
  assign txrdy = ~fifo_full;
  assign empty = fifo_empty;
  assign tx    = tx_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (data_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign bit_end   = (baud_cnt_q == div_q - 32'd1);
  assign last_data = (bit_cnt_q == {1'b0, len_q} + 3'd4);

  // tx_d is decoded from the current state, so tx trails the state register by one
  // clock; busy is registered the same way so both line up with the frame on the wire.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = bit_end ? 32'd0 : baud_cnt_q + 32'd1;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    len_d       = len_q;
    p_en_d      = p_en_q;
    ohel_d      = ohel_q;
    two_stop_d  = two_stop_q;
    tx_d        = 1'b1;
    pop         = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = 32'd0;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (last_data) begin
            bit_cnt_d = 3'd0;
            state_d   = p_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q ^ ohel_q;
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = 3'd0;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (bit_cnt_q[0] == two_stop_q) begin
            if (!fifo_empty) start_frame = 1'b1;
            else             state_d     = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pop the head word and freeze the configuration for the whole frame.
    if (start_frame) begin
      pop        = 1'b1;
      state_d    = ST_START;
      shift_d    = fifo_rdata;
      par_d      = 1'b0;
      len_d      = len;
      p_en_d     = p_en;
      ohel_d     = ohel;
      two_stop_d = two_stop;
      div_d      = div_tab[baud];
      baud_cnt_d = 32'd0;
      bit_cnt_d  = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 32'd0;
      div_q      <= 32'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_q      <= 1'b0;
      len_q      <= LEN_8;
      p_en_q     <= 1'b0;
      ohel_q     <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      len_q      <= len_d;
      p_en_q     <= p_en_d;
      ohel_q     <= ohel_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= (state_q != ST_IDLE);
      if (load && fifo_full) ovf_q <= 1'b1;
    end
  end

endmodule
